serial_tx: RTL and testbench



---
 rtl/serial_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_serial_tx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
//
// Single-clock asynchronous-serial transmitter. A parallel word is accepted
// over a valid/ready handshake and sent on a one-wire line as a frame:
// start bit (0), WIDTH data bits LSB-first, optional parity bit, stop bit (1).
// Every serial bit lasts CLKS_PER_BIT clock cycles.
//
// Parameters:
//   WIDTH         data bits per frame (1..16)
//   CLKS_PER_BIT  clk cycles per serial bit (>= 1)
//   PARITY_EN     1 inserts a parity bit after the data bits
//   PARITY_ODD    0 = even parity, 1 = odd parity (only with PARITY_EN = 1)
//
// Ports:
//   clk           rising-edge clock
//   asyncReset_n  asynchronous, active-low reset
//   txData        word to send, sampled only at accept
//   txValid       producer has a word on txData
//   txReady       block can accept a word this cycle (registered)
//   txOut         serial line, idle high (registered)
//   busy          frame in progress (registered)
//   done          one-cycle pulse on the cycle the block returns to IDLE
//
// Handshake: a word is accepted on a rising edge where txValid = 1 and
// txReady = 1. txReady is high only in IDLE, so txValid/txData are ignored
// while a frame is in flight; the producer may hold txValid high and the
// next word is taken on the first edge after the frame's done cycle.
// -----------------------------------------------------------------------------
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             asyncReset_n,
    input  logic [WIDTH-1:0] txData,
    input  logic             txValid,
    output logic             txReady,
    output logic             txOut,
    output logic             busy,
    output logic             done
);

    // Bit-period counter needs at least one bit even when CLKS_PER_BIT = 1.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [WIDTH-1:0]   shift_q,  shift_d;
    logic               parity_q, parity_d;

    // Registered outputs
    logic               tx_out_q,   tx_out_d;
    logic               tx_ready_q, tx_ready_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;

    logic               bit_end;
    logic               accept;

    assign bit_end = (cnt_q == CNT_LAST);
    assign accept  = txValid && tx_ready_q;

    // -------------------------------------------------------------------------
    // Process 1: state register (all flops, async active-low reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge asyncReset_n) begin
        if (!asyncReset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_out_q   <= 1'b1;
            // txReady stays low in reset and rises on the first edge after.
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_out_q   <= tx_out_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (accept) begin
                    shift_d  = txData;
                    // Parity is fixed from the latched word, so later
                    // shifting does not disturb it.
                    parity_d = (^txData) ^ PAR_ODD;
                    state_d  = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Process 3: outputs. They are decoded from the *next* state so that the
    // registered outputs line up with the state they describe: the start bit
    // is on the line from the accept edge onward.
    // -------------------------------------------------------------------------
    always_comb begin
        tx_out_d   = 1'b1;
        tx_ready_d = 1'b0;
        busy_d     = 1'b1;
        done_d     = 1'b0;

        unique case (state_d)
            S_IDLE: begin
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
            S_START:  tx_out_d = 1'b0;
            S_DATA:   tx_out_d = shift_d[0];
            S_PARITY: tx_out_d = parity_d;
            S_STOP:   tx_out_d = 1'b1;
            default: begin
                tx_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase

        // Only a completed stop bit produces done; reset never passes here.
        done_d = (state_q == S_STOP) && (state_d == S_IDLE);
    end

    assign txOut   = tx_out_q;
    assign txReady = tx_ready_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

  // clock / reset
  logic clk = 1'b0;
  logic asyncReset_n = 1'b1;
  always #5 clk = ~clk;

  // four configurations: base, even parity, odd parity, minimal
  localparam int W_A   [4] = '{8, 8, 8, 1};
  localparam int CPB_A [4] = '{4, 4, 4, 1};
  localparam int PEN_A [4] = '{0, 1, 1, 0};
  localparam int PODD_A[4] = '{0, 0, 1, 0};

  logic [3:0] tx_valid = '0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic       d3 = 1'b0;
  logic [3:0] tx_ready, tx_out, busy, done;

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_base (
    .clk(clk), .asyncReset_n(asyncReset_n), .txData(d0), .txValid(tx_valid[0]),
    .txReady(tx_ready[0]), .txOut(tx_out[0]), .busy(busy[0]), .done(done[0]));
  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .asyncReset_n(asyncReset_n), .txData(d1), .txValid(tx_valid[1]),
    .txReady(tx_ready[1]), .txOut(tx_out[1]), .busy(busy[1]), .done(done[1]));
  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .asyncReset_n(asyncReset_n), .txData(d2), .txValid(tx_valid[2]),
    .txReady(tx_ready[2]), .txOut(tx_out[2]), .busy(busy[2]), .done(done[2]));
  serial_tx #(.WIDTH(1), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_tiny (
    .clk(clk), .asyncReset_n(asyncReset_n), .txData(d3), .txValid(tx_valid[3]),
    .txReady(tx_ready[3]), .txOut(tx_out[3]), .busy(busy[3]), .done(done[3]));

  // scoreboard: one expected txOut value per clock cycle of the frame
  logic [0:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic set_data(input int d, input logic [15:0] v);
    case (d)
      0: d0 = v[7:0];
      1: d1 = v[7:0];
      2: d2 = v[7:0];
      default: d3 = v[0];
    endcase
  endtask

  // expected line waveform: start, data LSB-first, parity, stop
  task automatic push_frame(input int d, input logic [15:0] word);
    logic [0:0] par;
    par = PODD_A[d] != 0;
    for (int k = 0; k < CPB_A[d]; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < W_A[d]; i++) begin
      par = par ^ word[i];
      for (int k = 0; k < CPB_A[d]; k++) exp_q.push_back(word[i]);
    end
    if (PEN_A[d] != 0)
      for (int k = 0; k < CPB_A[d]; k++) exp_q.push_back(par);
    for (int k = 0; k < CPB_A[d]; k++) exp_q.push_back(1'b1);
  endtask

  // Called #1 after an edge with DUT d idle. Accepts on the next edge,
  // then replaces txData with next_data (ignored by the running frame).
  task automatic send(input int d, input logic [15:0] word,
                      input logic [15:0] next_data, input bit keep_valid);
    logic [0:0] e;
    check("ready_before", {31'd0, tx_ready[d]}, 32'd1);
    set_data(d, word);
    tx_valid[d] = 1'b1;
    @(posedge clk); #1;
    check("ready_after_acc", {31'd0, tx_ready[d]}, 32'd0);
    check("done_at_acc", {31'd0, done[d]}, 32'd0);
    if (!keep_valid) tx_valid[d] = 1'b0;
    set_data(d, next_data);
    push_frame(d, word);
    for (int j = 0; exp_q.size() > 0; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      e = exp_q.pop_front();
      check($sformatf("txout_d%0d_c%0d", d, j), {31'd0, tx_out[d]}, {31'd0, e});
      check("busy_frame", {31'd0, busy[d]}, 32'd1);
    end
    @(posedge clk); #1;
    check("done_pulse", {31'd0, done[d]}, 32'd1);
    check("busy_end", {31'd0, busy[d]}, 32'd0);
    check("ready_end", {31'd0, tx_ready[d]}, 32'd1);
    check("txout_end", {31'd0, tx_out[d]}, 32'd1);
  endtask

  task automatic idle_chk(input int d, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      check("idle_done", {31'd0, done[d]}, 32'd0);
      check("idle_busy", {31'd0, busy[d]}, 32'd0);
      check("idle_txout", {31'd0, tx_out[d]}, 32'd1);
      check("idle_ready", {31'd0, tx_ready[d]}, 32'd1);
    end
  endtask

  initial begin
    logic [15:0] w;
    // reset values, visible with no clock edge
    #2 asyncReset_n = 1'b0;
    #1;
    check("rst_txout", {28'd0, tx_out}, 32'hF);
    check("rst_ready", {28'd0, tx_ready}, 32'h0);
    check("rst_busy", {28'd0, busy}, 32'h0);
    check("rst_done", {28'd0, done}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) asyncReset_n = 1'b1;
    #1 check("ready_still_low", {28'd0, tx_ready}, 32'h0);
    @(posedge clk); #1;
    check("ready_after_rel", {28'd0, tx_ready}, 32'hF);

    // basic frame 0xA5, data scrambled mid-frame
    send(0, 16'hA5, 16'h5A, 1'b0);
    idle_chk(0, 2);
    // parity frames
    send(1, 16'h07, 16'hFF, 1'b0);
    idle_chk(1, 1);
    send(2, 16'h07, 16'h00, 1'b0);
    idle_chk(2, 1);
    send(2, 16'h00, 16'hFF, 1'b0);
    idle_chk(2, 1);
    // back-to-back with txValid held: second accept at E0+F+1
    send(0, 16'h3C, 16'hC3, 1'b1);
    send(0, 16'hC3, 16'h81, 1'b0);
    idle_chk(0, 1);
    // one-cycle bits, one-bit word
    send(3, 16'h1, 16'h0, 1'b0);
    idle_chk(3, 1);
    send(3, 16'h0, 16'h1, 1'b0);
    idle_chk(3, 1);
    // random words on the 8-bit configurations
    for (int r = 0; r < 6; r++) begin
      w = 16'($urandom_range(0, 255));
      send(r % 3, w, 16'($urandom_range(0, 255)), 1'b0);
      idle_chk(r % 3, 1);
    end

    // reset in the middle of DATA
    set_data(0, 16'h00);
    tx_valid[0] = 1'b1;
    @(posedge clk); #1;
    tx_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("pre_rst_txout", {31'd0, tx_out[0]}, 32'd0);
    check("pre_rst_busy", {31'd0, busy[0]}, 32'd1);
    asyncReset_n = 1'b0;
    tx_valid[0] = 1'b1;
    #1;
    check("mid_rst_txout", {31'd0, tx_out[0]}, 32'd1);
    check("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
    check("mid_rst_ready", {31'd0, tx_ready[0]}, 32'd0);
    check("mid_rst_done", {31'd0, done[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 check("rst_hold_ready", {31'd0, tx_ready[0]}, 32'd0);
    @(negedge clk);
    asyncReset_n = 1'b1;
    tx_valid[0] = 1'b0;
    @(posedge clk); #1;
    check("rel_ready", {31'd0, tx_ready[0]}, 32'd1);
    check("rel_busy", {31'd0, busy[0]}, 32'd0);
    check("rel_done", {31'd0, done[0]}, 32'd0);
    idle_chk(0, 40);
    send(0, 16'h96, 16'h00, 1'b0);
    idle_chk(0, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
